// File: rtl/decode_pkg.sv
// decode_pkg: instruction field positions and the decoded entry type (DECODE_ILLEGAL_EN adds the illegal flag)
package decode_pkg;
  localparam int OPCODE_W = 6;
  localparam int REG_W = 5;
  localparam int OPC_HI = 31, OPC_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int RSV_HI = 5, RSV_LO = 0;
  localparam int ITYPE_BIT = 30;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;
  // entries carry the widest supported imm/pc; the queue slices down to XLEN/PC_W
  localparam int IMM_MAX_W = 64;
  localparam int PC_MAX_W = 64;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_MAX_W-1:0] imm;
    logic [PC_MAX_W-1:0] pc;
    logic is_nop;
`ifdef DECODE_ILLEGAL_EN
    logic illegal;
`endif
  } decoded_ins_t;
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push and decode-side pop handshake (DECODE_ILLEGAL_EN adds out_illegal)
interface decode_queue_if
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int DEPTH = 4
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_ins;
  logic [PC_W-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [OPCODE_W-1:0] out_opcode;
  logic [REG_W-1:0] out_rs;
  logic [REG_W-1:0] out_rt;
  logic [REG_W-1:0] out_rd;
  logic [REG_W-1:0] out_shamt;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_pc;
  logic out_is_nop;
  logic [$clog2(DEPTH):0] count;
`ifdef DECODE_ILLEGAL_EN
  logic out_illegal;
`endif
  modport master (
    output flush, in_valid, in_ins, in_pc, out_ready,
    input in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_imm, out_pc,
    out_is_nop, count
`ifdef DECODE_ILLEGAL_EN
    , out_illegal
`endif
  );
  modport slave (
    input flush, in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_imm, out_pc,
    out_is_nop, count
`ifdef DECODE_ILLEGAL_EN
    , out_illegal
`endif
  );
endinterface

// File: rtl/ins_field_decode.sv
// ins_field_decode: combinational split of a raw instruction into a decoded entry (DECODE_ILLEGAL_EN flags reserved bits)
module ins_field_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic [31:0]     ins,
  input  logic [PC_W-1:0] pc,
  output decoded_ins_t    dec
);
  logic nop, r_type, i_type;
  // NOP zeroes everything naturally; rd/shamt only for R-type, imm only for I-type
  always_comb begin
    nop = ins == '0;
    i_type = ins[ITYPE_BIT];
    r_type = !nop && !i_type;
    dec = '0;
    dec.opcode = ins[OPC_HI:OPC_LO];
    dec.rs = ins[RS_HI:RS_LO];
    dec.rt = ins[RT_HI:RT_LO];
    dec.rd = r_type ? ins[RD_HI:RD_LO] : '0;
    dec.shamt = r_type ? ins[SH_HI:SH_LO] : '0;
    dec.imm = i_type ? IMM_MAX_W'({{(XLEN-IMM_W){ins[IMM_HI]}}, ins[IMM_HI:IMM_LO]}) : '0;
    dec.pc = PC_MAX_W'(pc);
    dec.is_nop = nop;
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = r_type && ins[RSV_HI:RSV_LO] != '0;
`endif
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: registered decode stage, field decoder feeding a DEPTH-entry FIFO (DECODE_ILLEGAL_EN adds out_illegal)
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  decoded_ins_t mem [DEPTH];
  decoded_ins_t dec, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic push, pop, full, unused;
  ins_field_decode #(.XLEN(XLEN), .PC_W(PC_W)) u_dec (.ins(bus.in_ins), .pc(bus.in_pc), .dec(dec));
  assign full = cnt == (AW+1)'(DEPTH);
  assign bus.in_ready = !full && !bus.flush && rst_n;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  // pointers wrap naturally; flush wins over a simultaneous pop
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage needs no reset: push is blocked while rst_n is low
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end
  assign bus.out_valid = cnt != '0;
  assign head = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_opcode = head.opcode;
  assign bus.out_rs = head.rs;
  assign bus.out_rt = head.rt;
  assign bus.out_rd = head.rd;
  assign bus.out_shamt = head.shamt;
  assign bus.out_imm = head.imm[XLEN-1:0];
  assign bus.out_pc = head.pc[PC_W-1:0];
  assign bus.out_is_nop = head.is_nop;
  assign bus.count = cnt;
  assign unused = ^{head.imm, head.pc};
`ifdef DECODE_ILLEGAL_EN
  assign bus.out_illegal = head.illegal;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed vector table plus handshake corner sequences (DECODE_ILLEGAL_EN checks out_illegal)
module tb_decode_queue;
  localparam int XLEN = 32, PC_W = 32, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  decode_queue_if #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();
  decode_queue #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [5:0] op;
    logic [4:0] rs, rt, rd, sh;
    logic [31:0] imm;
    logic nop;
    logic ill;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_head(input vec_t e);
    chk("out_valid", 64'(bus.out_valid), 64'(1));
    chk("opcode", 64'(bus.out_opcode), 64'(e.op));
    chk("rs", 64'(bus.out_rs), 64'(e.rs));
    chk("rt", 64'(bus.out_rt), 64'(e.rt));
    chk("rd", 64'(bus.out_rd), 64'(e.rd));
    chk("shamt", 64'(bus.out_shamt), 64'(e.sh));
    chk("imm", 64'(bus.out_imm), 64'(e.imm));
    chk("pc", 64'(bus.out_pc), 64'(e.pc));
    chk("is_nop", 64'(bus.out_is_nop), 64'(e.nop));
`ifdef DECODE_ILLEGAL_EN
    chk("illegal", 64'(bus.out_illegal), 64'(e.ill));
`endif
  endtask
  task automatic check_empty(input string tag);
    chk({tag, " count"}, 64'(bus.count), 64'(0));
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, " out_pc"}, 64'(bus.out_pc), 64'(0));
    chk({tag, " out_imm"}, 64'(bus.out_imm), 64'(0));
    chk({tag, " out_rs"}, 64'(bus.out_rs), 64'(0));
  endtask
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1;
    bus.in_ins = ins;
    bus.in_pc = pc;
    step();
    bus.in_valid = 0;
  endtask
  initial begin
    v[0] = '{32'h0000_0000, 32'h100, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
    v[1] = '{32'h012A_5940, 32'h104, 6'h00, 5'd9, 5'd10, 5'd11, 5'd5, 32'h0000_0000, 1'b0, 1'b0};
    v[2] = '{32'h4000_FFFF, 32'h108, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[3] = '{32'h4000_7FFF, 32'h10C, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_7FFF, 1'b0, 1'b0};
    v[4] = '{32'h8C4B_0010, 32'h110, 6'h23, 5'd2, 5'd11, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b1};
    v[5] = '{32'h012A_5941, 32'h114, 6'h00, 5'd9, 5'd10, 5'd11, 5'd5, 32'h0000_0000, 1'b0, 1'b1};
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_ins = '0;
    bus.in_pc = '0;
    bus.out_ready = 0;
    step();
    check_empty("reset");
    chk("in_ready in reset", 64'(bus.in_ready), 64'(0));
    rst_n = 1;
    #1;
    chk("in_ready after reset", 64'(bus.in_ready), 64'(1));
    // table: push one, check it the next cycle, pop it, check empty
    for (int i = 0; i < 6; i++) begin
      push(v[i].ins, v[i].pc);
      chk("count after push", 64'(bus.count), 64'(1));
      check_head(v[i]);
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      check_empty("after pop");
    end
    // fill with consumer stalled: 5th push must be refused
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1;
      bus.in_ins = 32'h4000_0000 | 32'(i);
      bus.in_pc = 32'h200 + 32'(4 * i);
      #1;
      chk("in_ready while filling", 64'(bus.in_ready), 64'(i < 4));
      step();
      chk("head held", 64'(bus.out_pc), 64'h200);
    end
    bus.in_valid = 0;
    chk("count full", 64'(bus.count), 64'(4));
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("drain valid", 64'(bus.out_valid), 64'(1));
      chk("drain pc", 64'(bus.out_pc), 64'h200 + 64'(4 * k));
      chk("drain imm", 64'(bus.out_imm), 64'(k));
      step();
    end
    bus.out_ready = 0;
    check_empty("drained");
    // simultaneous push and pop at count 2
    push(32'h4000_0001, 32'h300);
    push(32'h4000_0002, 32'h304);
    chk("count 2", 64'(bus.count), 64'(2));
    bus.in_valid = 1;
    bus.in_ins = 32'h4000_0003;
    bus.in_pc = 32'h308;
    bus.out_ready = 1;
    #1;
    chk("head A before push+pop", 64'(bus.out_pc), 64'h300);
    step();
    bus.in_valid = 0;
    chk("count after push+pop", 64'(bus.count), 64'(2));
    chk("head B", 64'(bus.out_pc), 64'h304);
    step();
    bus.out_ready = 0;
    chk("head C", 64'(bus.out_pc), 64'h308);
    chk("count 1", 64'(bus.count), 64'(1));
    // flush with a pending push
    bus.flush = 1;
    bus.in_valid = 1;
    bus.in_ins = 32'h4000_00EE;
    bus.in_pc = 32'h3F0;
    #1;
    chk("in_ready during flush", 64'(bus.in_ready), 64'(0));
    step();
    bus.flush = 0;
    bus.in_valid = 0;
    check_empty("flush");
    step();
    check_empty("flush+1");
    push(32'h4000_00F0, 32'h400);
    chk("post-flush count", 64'(bus.count), 64'(1));
    chk("post-flush head", 64'(bus.out_pc), 64'h400);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    // reset in the middle of a drain
    push(32'h4000_0010, 32'h500);
    push(32'h4000_0011, 32'h504);
    push(32'h4000_0012, 32'h508);
    chk("count 3", 64'(bus.count), 64'(3));
    bus.out_ready = 1;
    step();
    chk("mid-drain head", 64'(bus.out_pc), 64'h504);
    rst_n = 0;
    step();
    rst_n = 1;
    bus.out_ready = 0;
    check_empty("mid reset");
`ifdef DECODE_ILLEGAL_EN
    push(32'h012A_5941, 32'h600);
    chk("illegal set", 64'(bus.out_illegal), 64'(1));
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("illegal empty", 64'(bus.out_illegal), 64'(0));
    push(32'h4000_FFFF, 32'h604);
    chk("illegal I-type", 64'(bus.out_illegal), 64'(0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
